mult_error_eval: RTL and testbench
==================================

Name: mult_error_eval

Overview:
- Downstream consumer of the 16-bit approximate multiplier.
- The bench or GA harness drives operand pairs into the approximate multiplier. This block takes each operand pair together with the resulting approximate product, recomputes the exact product and accumulates error metrics over a run of N samples.
- The metrics are total absolute error, maximum absolute error with the operands that caused it, and mismatch count. The GA flow reads them as the fitness inputs for each candidate multiplier.

Parameters:
- W, 16, operand width; product width is 2W.
- CNT_W, 20, sample-counter width; sets the maximum samples per run.
- ACC_W, 2*W+CNT_W, width of the absolute-error accumulator; cannot overflow by construction.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begins a run; sampled only in IDLE.
- num_samples  in  CNT_W  sample count for the run; latched on start.
- in_valid  in  1  a, b and p_approx are valid.
- in_ready  out  1  block accepts a sample this cycle.
- a  in  W  multiplicand given to the approximate multiplier.
- b  in  W  multiplier operand given to the approximate multiplier.
- p_approx  in  2W  approximate product for a, b, in the same cycle.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when results are final.
- sum_abs_err  out  ACC_W  sum of |a*b - p_approx|.
- max_abs_err  out  2W  largest single absolute error.
- max_err_a  out  W  operand a of the first sample reaching max_abs_err.
- max_err_b  out  W  operand b of the first sample reaching max_abs_err.
- err_count  out  CNT_W  number of samples where p_approx != a*b.

Behaviour:
- Reset: all outputs and internal registers are 0; state is IDLE.
  - Reset asserted mid-run aborts the run immediately; no done pulse is produced.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - On start=1: clear all result registers and the accepted/target counters, latch num_samples.
  - Go to DONE if num_samples==0, else go to RUN.
- RUN:
  - in_ready=1, busy=1.
  - A sample is accepted on an edge where in_valid && in_ready.
  - The accepted counter increments on each accept.
  - When the accept takes the count to num_samples, in_ready deasserts combinationally from the next cycle and the state moves to DRAIN.
- DRAIN:
  - in_ready=0, busy=1.
  - Stay 2 cycles while the pipeline empties, then go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0; then return to IDLE.
- start is ignored outside IDLE.
- Results hold their values until the next accepted start or reset.
- Pipeline, with the sample accepted at edge k:
  - S1 at edge k: register a, b, p_approx.
  - S2 at edge k+1: register exact = a*b (2W bits unsigned), the absolute difference, and the mismatch flag.
  - S3 at edge k+2: update the accumulators.
- If k is the edge that accepts the last sample: results are final after edge k+2 and done is high in the cycle after edge k+3.
- Arithmetic:
  - All arithmetic is unsigned.
  - The absolute difference is computed as the larger minus the smaller, so p_approx > exact is handled.
  - The sum adds the difference zero-extended to ACC_W.
- Max tracking:
  - Update only on strict greater-than; on ties the first occurrence is kept.
  - A max of 0 leaves max_err_a and max_err_b at 0.
- err_count increments only when the difference is nonzero.
- in_valid while in_ready=0 is not consumed and has no effect.

Decomposition:
- mult_eval_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the default W, CNT_W and ACC_W constants;
  - the DRAIN length constant, set to 2.
- One sub-module, mult_abs_err:
  - covers pipeline stage S2;
  - registered inputs a, b, p_approx;
  - registered outputs exact, abs_err, mismatch;
  - shares clk/rst_n.
- The top level holds the FSM, the counters, and stages S1 and S3.

Test Plan:
- Zero-sample run: start with num_samples=0.
  - done pulses 2 cycles after start; busy stays 0; in_ready never asserts; all results are 0.
- Exact run: samples (3,5,15), (65535,65535,0xFFFE0001), (0,1234,0).
  - sum_abs_err=0, max_abs_err=0, err_count=0, max_err_a=0, max_err_b=0.
- Error run: samples (10,10,90), (100,2,210), (7,7,40), (2,3,8).
  - Individual errors are 10, 10, 9, 2.
  - sum_abs_err=31, max_abs_err=10, max_err_a=10, max_err_b=10 (first of the tie kept), err_count=4.
- Handshake timing: num_samples=3 with in_valid toggling on alternate cycles, held high after the 3rd accept, and start pulsed while busy.
  - Exactly 3 samples are accepted.
  - in_ready=0 after the 3rd accept.
  - start has no effect while busy.
  - done appears exactly 3 edges after the last accept.
- Reset mid-run: num_samples=4; assert rst_n=0 after 2 accepts.
  - All outputs are 0 and there is no done pulse.
  - A new run of (10,10,90) then gives sum_abs_err=10 and err_count=1.
- Back-to-back runs: the second start comes 1 cycle after done.
  - Results clear at start and reflect only the second run.

Source files
------------

// File: rtl/mult_eval_pkg.sv
// Shared constants and FSM state type for the approximate-multiplier
// error evaluator.
package mult_eval_pkg;

   localparam int W_DEF     = 16;
   localparam int CNT_W_DEF = 20;
   localparam int ACC_W_DEF = 2 * W_DEF + CNT_W_DEF;
   localparam int DRAIN_LEN = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

endpackage

// File: rtl/mult_abs_err.sv
// S2 stage: recompute the exact product and the absolute error against
// the approximate product, carrying the operands along for max tracking.
module mult_abs_err
   import mult_eval_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           i_vld,
   input  logic [W-1:0]   i_a,
   input  logic [W-1:0]   i_b,
   input  logic [2*W-1:0] i_p,
   output logic           o_vld,
   output logic [W-1:0]   o_a,
   output logic [W-1:0]   o_b,
   output logic [2*W-1:0] o_exact,
   output logic [2*W-1:0] o_abs_err,
   output logic           o_mismatch
);

   logic [2*W-1:0] w_exact;
   logic [2*W-1:0] w_diff;

   assign w_exact = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};
   // Larger minus smaller so an over-estimating multiplier is handled.
   assign w_diff  = (w_exact >= i_p) ? (w_exact - i_p) : (i_p - w_exact);

   logic           r_vld;
   logic [W-1:0]   r_a;
   logic [W-1:0]   r_b;
   logic [2*W-1:0] r_exact;
   logic [2*W-1:0] r_abs_err;
   logic           r_mismatch;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld      <= 1'b0;
         r_a        <= '0;
         r_b        <= '0;
         r_exact    <= '0;
         r_abs_err  <= '0;
         r_mismatch <= 1'b0;
      end else begin
         r_vld <= i_vld;
         if (i_vld) begin
            r_a        <= i_a;
            r_b        <= i_b;
            r_exact    <= w_exact;
            r_abs_err  <= w_diff;
            r_mismatch <= (w_exact != i_p);
         end
      end
   end

   assign o_vld      = r_vld;
   assign o_a        = r_a;
   assign o_b        = r_b;
   assign o_exact    = r_exact;
   assign o_abs_err  = r_abs_err;
   assign o_mismatch = r_mismatch;

endmodule

// File: rtl/mult_error_eval.sv
// Accumulates error metrics of an approximate multiplier over a run of
// samples: total/max absolute error, max-error operands, mismatch count.
module mult_error_eval
   import mult_eval_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter int ACC_W = 2 * W + CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_samples,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic [2*W-1:0]   p_approx,
   output logic             busy,
   output logic             done,
   output logic [ACC_W-1:0] sum_abs_err,
   output logic [2*W-1:0]   max_abs_err,
   output logic [W-1:0]     max_err_a,
   output logic [W-1:0]     max_err_b,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_LEN - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_in_ready;
   logic             w_busy;
   logic             w_clear;
   logic             w_accept;
   logic [CNT_W-1:0] r_acc_cnt;
   logic [CNT_W-1:0] r_target;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [1:0]       r_drain_cnt;
   logic             r_done;

   assign w_cnt_nxt = r_acc_cnt + CNT_W'(1);
   assign w_accept  = in_valid && w_in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_busy      = 1'b0;
      w_clear     = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_clear     = 1'b1;
               w_state_nxt = (num_samples == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            w_in_ready = 1'b1;
            w_busy     = 1'b1;
            if (in_valid && (w_cnt_nxt == r_target))
               w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            w_busy = 1'b1;
            if (r_drain_cnt == DRAIN_LAST)
               w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc_cnt   <= '0;
         r_target    <= '0;
         r_drain_cnt <= '0;
         r_done      <= 1'b0;
      end else begin
         if (w_clear) begin
            r_acc_cnt <= '0;
            r_target  <= num_samples;
         end else if (w_accept) begin
            r_acc_cnt <= w_cnt_nxt;
         end
         if (r_state == ST_DRAIN) r_drain_cnt <= r_drain_cnt + 2'd1;
         else                     r_drain_cnt <= '0;
         // Registered so done lands one cycle after the DONE state.
         r_done <= (r_state == ST_DONE);
      end
   end

   // S1: capture the accepted sample
   logic           r_s1_vld;
   logic [W-1:0]   r_s1_a;
   logic [W-1:0]   r_s1_b;
   logic [2*W-1:0] r_s1_p;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_vld <= 1'b0;
         r_s1_a   <= '0;
         r_s1_b   <= '0;
         r_s1_p   <= '0;
      end else begin
         r_s1_vld <= w_accept;
         if (w_accept) begin
            r_s1_a <= a;
            r_s1_b <= b;
            r_s1_p <= p_approx;
         end
      end
   end

   logic           w_s2_vld;
   logic [W-1:0]   w_s2_a;
   logic [W-1:0]   w_s2_b;
   logic [2*W-1:0] w_s2_exact;
   logic [2*W-1:0] w_s2_abs;
   logic           w_s2_mis;

   mult_abs_err #(
      .W (W)
   ) u_abs_err (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_vld      (r_s1_vld),
      .i_a        (r_s1_a),
      .i_b        (r_s1_b),
      .i_p        (r_s1_p),
      .o_vld      (w_s2_vld),
      .o_a        (w_s2_a),
      .o_b        (w_s2_b),
      .o_exact    (w_s2_exact),
      .o_abs_err  (w_s2_abs),
      .o_mismatch (w_s2_mis)
   );

   // S3: accumulators
   logic [ACC_W-1:0] r_sum;
   logic [2*W-1:0]   r_max;
   logic [W-1:0]     r_max_a;
   logic [W-1:0]     r_max_b;
   logic [CNT_W-1:0] r_err_cnt;
   logic [ACC_W-1:0] w_abs_ext;

   assign w_abs_ext = {{(ACC_W - 2 * W){1'b0}}, w_s2_abs};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum     <= '0;
         r_max     <= '0;
         r_max_a   <= '0;
         r_max_b   <= '0;
         r_err_cnt <= '0;
      end else if (w_clear) begin
         r_sum     <= '0;
         r_max     <= '0;
         r_max_a   <= '0;
         r_max_b   <= '0;
         r_err_cnt <= '0;
      end else if (w_s2_vld) begin
         r_sum <= r_sum + w_abs_ext;
         // Strict compare keeps the first sample of a tie.
         if (w_s2_abs > r_max) begin
            r_max   <= w_s2_abs;
            r_max_a <= w_s2_a;
            r_max_b <= w_s2_b;
         end
         if (w_s2_mis) r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
   end

   logic w_unused;
   assign w_unused = ^w_s2_exact;

   assign in_ready    = w_in_ready;
   assign busy        = w_busy;
   assign done        = r_done;
   assign sum_abs_err = r_sum;
   assign max_abs_err = r_max;
   assign max_err_a   = r_max_a;
   assign max_err_b   = r_max_b;
   assign err_count   = r_err_cnt;

endmodule

// File: tb/tb_mult_error_eval.sv
// Directed-vector bench for mult_error_eval.
module tb_mult_error_eval;

   localparam int W     = 16;
   localparam int CNT_W = 20;
   localparam int ACC_W = 2 * W + CNT_W;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [CNT_W-1:0] num_samples;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     a;
   logic [W-1:0]     b;
   logic [2*W-1:0]   p_approx;
   logic             busy;
   logic             done;
   logic [ACC_W-1:0] sum_abs_err;
   logic [2*W-1:0]   max_abs_err;
   logic [W-1:0]     max_err_a;
   logic [W-1:0]     max_err_b;
   logic [CNT_W-1:0] err_count;

   mult_error_eval #(
      .W     (W),
      .CNT_W (CNT_W),
      .ACC_W (ACC_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .num_samples (num_samples),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .p_approx    (p_approx),
      .busy        (busy),
      .done        (done),
      .sum_abs_err (sum_abs_err),
      .max_abs_err (max_abs_err),
      .max_err_a   (max_err_a),
      .max_err_b   (max_err_b),
      .err_count   (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [W-1:0]   sa[8];
   logic [W-1:0]   sb[8];
   logic [2*W-1:0] sp[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int n);
      start       = 1'b1;
      num_samples = CNT_W'(n);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         if (done) seen = 1;
      end
      chk(tag, 64'(seen), 64'd1);
   endtask

   task automatic run(input int n, input string tag);
      do_start(n);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         a        = sa[i];
         b        = sb[i];
         p_approx = sp[i];
         tick();
      end
      in_valid = 1'b0;
      wait_done(tag);
   endtask

   task automatic chk_res(input string tag, input logic [63:0] s,
                          input logic [63:0] m, input logic [63:0] ma,
                          input logic [63:0] mb, input logic [63:0] e);
      chk({tag, "_sum"}, 64'(sum_abs_err), s);
      chk({tag, "_max"}, 64'(max_abs_err), m);
      chk({tag, "_max_a"}, 64'(max_err_a), ma);
      chk({tag, "_max_b"}, 64'(max_err_b), mb);
      chk({tag, "_errcnt"}, 64'(err_count), e);
   endtask

   initial begin
      int accepts;
      int last_edge;
      int edge_n;
      bit acc;
      bit seen;
      bit done_early;

      rst_n       = 1'b0;
      start       = 1'b0;
      num_samples = '0;
      in_valid    = 1'b0;
      a           = '0;
      b           = '0;
      p_approx    = '0;
      tick();
      tick();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk_res("rst", 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      tick();

      // zero-sample run
      do_start(0);
      chk("zero_busy", 64'(busy), 64'd0);
      chk("zero_ready", 64'(in_ready), 64'd0);
      chk("zero_done_early", 64'(done), 64'd0);
      tick();
      chk("zero_done", 64'(done), 64'd1);
      chk("zero_busy2", 64'(busy), 64'd0);
      tick();
      chk("zero_done_pulse", 64'(done), 64'd0);
      chk_res("zero", 0, 0, 0, 0, 0);

      // exact run
      sa[0] = 3;      sb[0] = 5;      sp[0] = 15;
      sa[1] = 16'hFFFF; sb[1] = 16'hFFFF; sp[1] = 32'hFFFE0001;
      sa[2] = 0;      sb[2] = 1234;   sp[2] = 0;
      run(3, "exact_done");
      chk_res("exact", 0, 0, 0, 0, 0);
      tick();

      // error run, tie on max kept at first sample
      sa[0] = 10;  sb[0] = 10; sp[0] = 90;
      sa[1] = 100; sb[1] = 2;  sp[1] = 210;
      sa[2] = 7;   sb[2] = 7;  sp[2] = 40;
      sa[3] = 2;   sb[3] = 3;  sp[3] = 8;
      run(4, "err_done");
      chk_res("err", 31, 10, 10, 10, 4);
      tick();

      // handshake: in_valid toggling, held high after last accept
      do_start(3);
      chk("hs_busy", 64'(busy), 64'd1);
      accepts   = 0;
      last_edge = -1;
      seen      = 0;
      for (edge_n = 0; edge_n < 30 && !seen; edge_n++) begin
         in_valid = (accepts < 3) ? (edge_n % 2 == 0) : 1'b1;
         start    = (edge_n == 1 || edge_n == 5);
         num_samples = 20'd7;
         a        = 16'(4 + accepts);
         b        = 16'(4 + accepts);
         p_approx = (accepts == 1) ? 32'd20 : 32'(16'(4 + accepts) * 16'(4 + accepts));
         if (accepts >= 3) begin
            a = 100; b = 100; p_approx = 0;
         end
         if (accepts == 3 && edge_n == last_edge + 1)
            chk("hs_ready_low", 64'(in_ready), 64'd0);
         acc = in_valid && in_ready;
         tick();
         if (acc) begin
            accepts++;
            last_edge = edge_n;
         end
         if (done) begin
            seen = 1;
            chk("hs_done_lat", 64'(edge_n - last_edge), 64'd3);
         end
      end
      in_valid = 1'b0;
      start    = 1'b0;
      chk("hs_done_seen", 64'(seen), 64'd1);
      chk("hs_accepts", 64'(accepts), 64'd3);
      chk_res("hs", 5, 5, 5, 5, 1);
      tick();
      chk("hs_idle_busy", 64'(busy), 64'd0);
      tick();
      chk("hs_idle_busy2", 64'(busy), 64'd0);
      chk("hs_hold_sum", 64'(sum_abs_err), 64'd5);

      // reset mid-run
      do_start(4);
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         a = 9; b = 9; p_approx = 1;
         tick();
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #2;
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_ready", 64'(in_ready), 64'd0);
      chk_res("mrst", 0, 0, 0, 0, 0);
      tick();
      rst_n = 1'b1;
      done_early = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done) done_early = 1;
      end
      chk("mrst_no_done", 64'(done_early), 64'd0);
      chk("mrst_idle_sum", 64'(sum_abs_err), 64'd0);
      sa[0] = 10; sb[0] = 10; sp[0] = 90;
      run(1, "mrst_done");
      chk("mrst_sum", 64'(sum_abs_err), 64'd10);
      chk("mrst_errcnt", 64'(err_count), 64'd1);

      // back-to-back: first run then second start one cycle after done
      sa[0] = 10;  sb[0] = 10; sp[0] = 90;
      sa[1] = 100; sb[1] = 2;  sp[1] = 210;
      run(2, "b2b1_done");
      chk_res("b2b1", 20, 10, 10, 10, 2);
      tick();
      sa[0] = 3; sb[0] = 4; sp[0] = 13;
      sa[1] = 2; sb[1] = 2; sp[1] = 4;
      do_start(2);
      chk_res("b2b_clr", 0, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         a = sa[i]; b = sb[i]; p_approx = sp[i];
         tick();
      end
      in_valid = 1'b0;
      wait_done("b2b2_done");
      chk_res("b2b2", 1, 1, 3, 4, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
